// File: rtl/operand_arbiter_pkg.sv
// Shared definitions for the operand arbiter: FSM encodings, datapath width
// and requester count.
package operand_arbiter_pkg;

  localparam int DATA_W = 8;
  localparam int NREQ   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEL  = 2'b01,
    ACK  = 2'b10
  } state_t;

endpackage

// File: rtl/operand_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping 3 -> 0.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] g,
  output logic       any_req
);
  import operand_arbiter_pkg::*;

  logic       found;
  logic [1:0] idx;

  always_comb begin
    g     = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/operand_arbiter.sv
// Round-robin sequencer sharing one byte-select + adder path among four
// requesters; accumulates granted bytes into sum with a sticky carry.
module operand_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] a3,
  input  logic              clear,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [3:0]        ack,
  output logic [DATA_W-1:0] sum,
  output logic              carry,
  output logic [1:0]        fsm_state
);
  import operand_arbiter_pkg::*;

  state_t            state, state_n;
  logic [1:0]        ptr, ptr_n, sel_n, grant;
  logic              busy_n, carry_n, any_req, cout;
  logic [3:0]        ack_n;
  logic [DATA_W-1:0] sum_n, d, add;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr),
    .g       (grant),
    .any_req (any_req)
  );

  always_comb begin
    d = a0;
    case (sel)
      2'd0:    d = a0;
      2'd1:    d = a1;
      2'd2:    d = a2;
      default: d = a3;
    endcase
  end

  assign {cout, add} = {1'b0, sum} + {1'b0, d};

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    ack_n   = '0;
    sum_n   = sum;
    carry_n = carry;
    case (state)
      IDLE: begin
        if (any_req) begin
          sel_n   = grant;
          state_n = SEL;
        end
      end
      SEL: begin
        sum_n   = add;
        carry_n = carry | cout;
        ack_n   = 4'b0001 << sel;
        ptr_n   = sel + 2'd1;
        state_n = ACK;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // clear wins over the accumulate but leaves the handshake untouched
    if (clear) begin
      sum_n   = '0;
      carry_n = 1'b0;
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      busy  <= 1'b0;
      ack   <= 4'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      busy  <= busy_n;
      ack   <= ack_n;
      sum   <= sum_n;
      carry <= carry_n;
    end
  end

  assign fsm_state = state;

endmodule

// File: doc/operand_arbiter.md
# operand_arbiter

Round-robin arbiter and sequencer that shares one 8-bit operand path (4:1 byte select feeding an 8-bit adder) among four requesters. Each granted requester's byte is selected, added into an 8-bit running accumulator with a sticky carry, and acknowledged with a one-cycle pulse. It sits in the BitAdder datapath, driving the byte-select lines and owning the accumulator register.

## Interface
Parameters:
- DATA_W, 8, operand and accumulator width
- Defaults only; DATA_W other than 8 is not supported in this revision.

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  4  request per requester; bit i belongs to operand ai
- a0, a1, a2, a3  in  8 each  requester operands; must be stable from req rise until ack
- clear  in  1  synchronous clear of sum and carry
- sel  out  2  index of the current grant (byte select)
- busy  out  1  high in SEL and ACK states
- ack  out  4  one-hot, one-cycle acknowledge to the granted requester
- sum  out  8  accumulator value
- carry  out  1  sticky overflow flag

## Operation
- FSM states: IDLE, SEL, ACK. All outputs are registered.
- IDLE: if req != 0, choose grant g as the first set bit of req searching upward from pointer ptr, wrapping 3->0. Then sel <= g, state <= SEL. If req == 0, stay in IDLE.
- SEL: the selected byte d = a[sel]. Then sum <= sum + d (mod 256), carry <= carry | cout, ack[sel] <= 1, ptr <= sel + 1 (mod 4), state <= ACK.
- ACK: ack returns to 0 and req is not sampled. Then state <= IDLE. The requester must drop req no later than the ACK cycle, or it becomes eligible again in IDLE.
- Round-robin fairness: with all four requests held, grants issue in the order ptr, ptr+1, ... and wrap. No requester waits more than 3 other grants.
- clear: takes priority over the SEL update. If clear and SEL coincide on the same edge, sum <= 0 and carry <= 0, the add is discarded, and ack is still issued and ptr still advances. The FSM is otherwise unaffected.
- req bits that drop during SEL do not cancel the transfer already granted.
- Reset values: state IDLE, ptr 0, sel 0, busy 0, ack 0, sum 0, carry 0.
- Reset mid-operation: outputs take their reset values immediately, with no ack for the interrupted transfer.

## Timing
- Request sampled in IDLE at cycle N:
  - sel and busy are valid from cycle N+1.
  - ack, the sum update and the carry update are visible in cycle N+2.
  - The FSM is back in IDLE at cycle N+3.
- Throughput: one transfer per 3 cycles. Back-to-back grants put req-sample cycles 3 apart.
- busy = (state != IDLE). It is registered and goes high one cycle after sampling.
- sel holds its last value while in IDLE.
- No combinational path from any input to any output.

## Structure
- Shared package holds:
  - state encodings IDLE=2'b00, SEL=2'b01, ACK=2'b10
  - DATA_W = 8
  - requester count NREQ = 4
- Sub-module rr_pick4 is a purely combinational round-robin picker. Inputs are req[3:0] and ptr[1:0]; outputs are grant index g[1:0] and any_req. It is reused by later arbiters.
- The 4:1 byte select and the adder are inline in operand_arbiter. The select must be a complete combinational mux covering all data and select inputs.

## Test plan
- Reset: assert reset mid-SEL, with req=0001 and a0=8'h10 → same cycle sum=0, carry=0, ack=0, busy=0. After release with req held, the first ack goes to requester 0 and sum=8'h10.
- Single transfer: req=0100, a2=8'h2A → sel=2 at N+1, ack=0100 and sum=8'h2A at N+2, IDLE at N+3.
- Round-robin: req=1111 held, with a0..a3 = 1,2,3,4, dropping each bit on its ack → ack order 0,1,2,3, sum=8'h0A, ptr back to 0.
- Wrap and carry: sum preloaded to 8'hF0, then a1=8'h20 → sum=8'h10 and carry=1. A following a1=8'h01 gives sum=8'h11 with carry still 1.
- Clear collision: clear asserted on the SEL edge for a3=8'h55 → sum=0, carry=0, ack=1000 still issued, ptr=0.
- Fairness: requester 3 held continuously while requesters 0 and 1 re-request after every ack → requester 3 is granted within 3 grants of asserting req.
